regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter in front of the CPU register file's single write port. It merges single-cycle ALU results and variable-latency load (LSU) results into one registered write stream (write enable, address, data). LSU results queue in a small FIFO, and a starvation guard guarantees that queue drains. A pending-destination query lets decode hold off reads of registers whose load result has not yet been written.

## Interface
Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- DEPTH, 4, LSU FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before forced drain (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted this cycle
- i_alu_rd  in  AW  ALU destination
- i_alu_data  in  XLEN  ALU result
- i_lsu_valid  in  1  load result valid
- o_lsu_ready  out  1  load result accepted (equals FIFO not full)
- i_lsu_rd  in  AW  load destination
- i_lsu_data  in  XLEN  load data
- o_wr_en  out  1  register file write enable
- o_wr_addr  out  AW  register file write address
- o_wr_data  out  XLEN  register file write data
- i_chk_rd  in  AW  destination to query
- o_chk_pending  out  1  i_chk_rd is held in the FIFO

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle.
- Once valid is raised, the source holds valid, rd and data stable until the transfer.
- ALU path:
  - Highest priority; no buffering.
  - o_alu_ready = 1, except during a forced-drain cycle.
- LSU path:
  - An accepted result is pushed into the FIFO.
  - o_lsu_ready = !full, using registered occupancy. A full FIFO does not accept, even if it pops in the same cycle.
- Selection each cycle:
  - If an ALU transfer occurs, the ALU result is written.
  - Otherwise, if the FIFO is non-empty, the head is popped and written.
  - Otherwise nothing is written.
- Forced drain:
  - starve_cnt increments each cycle the FIFO is non-empty and not popped.
  - starve_cnt clears on any pop or when the FIFO is empty.
  - When starve_cnt == STARVE_LIMIT, o_alu_ready = 0 for one cycle, the head pops, and the count clears.
- x0: any result with rd == 0 is accepted normally but produces o_wr_en = 0 (discarded). A popped x0 entry still counts as a pop.
- Pending check: o_chk_pending = 1 when any valid FIFO entry has rd == i_chk_rd and i_chk_rd != 0. It is combinational from FIFO contents.
- Ordering: LSU results write in acceptance order. No ordering is enforced between the ALU and LSU streams; hazard control is the caller's job.

## Timing
- Reset values (rst_n low at a rising edge):
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0.
  - FIFO empty; starve_cnt = 0.
  - Consequently o_lsu_ready = 1, o_alu_ready = 1, o_chk_pending = 0.
- Reset mid-operation discards all queued entries; no write is emitted for them.
- ALU latency: transfer at edge N → o_wr_en/addr/data valid in cycle N+1, one cycle only.
- LSU latency: push at edge N → earliest write output in cycle N+2.
- Throughput: one write per cycle.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Pointer wrap: pointers are log2(DEPTH)+1 bits. Full and empty are distinguished by the MSB.

## Configuration
- REGFILE_WB_PENDING_CHK_EN defined: the o_chk_pending comparator array is built as described.
- Not defined: o_chk_pending is tied to 0, and no comparators or FIFO address-visibility logic are generated. The port stays present.

## Structure
- Shared package/header regfile_wb_pkg:
  - XLEN and AW defaults.
  - wb_req_t {rd, data} (or equivalent packed-width localparam).
  - STARVE_LIMIT default.
- One sub-module, wb_fifo:
  - Synchronous FIFO of wb_req_t with push/pop, full/empty, and an entry-visibility bus for the pending check.
- The arbiter owns selection, starve_cnt and the output register.

## Test plan
- Reset: hold rst_n = 0 with both valids high → o_wr_en = 0, o_lsu_ready = 1, o_alu_ready = 1. After release, the first ALU transfer (rd = 3, data = 0xA5A5A5A5) → o_wr_en = 1, addr 3, data 0xA5A5A5A5 one cycle later.
- Arbitration: ALU (rd = 1, 0x11) and LSU (rd = 2, 0x22) valid in the same cycle → write rd 1 next cycle, then rd 2 the following cycle.
- Backpressure: with ALU valid continuously, push 4 LSU results → o_lsu_ready = 0 on the 5th. Release ALU → 4 writes in push order; o_lsu_ready returns to 1 after the first pop.
- Starvation: ALU valid every cycle, one LSU entry queued → after 8 waiting cycles, o_alu_ready = 0 for exactly one cycle and the LSU entry is written.
- x0 and pending: LSU rd = 0 and rd = 7 queued while ALU is busy; query i_chk_rd = 7 → o_chk_pending = 1, and i_chk_rd = 0 → 0. On drain, the x0 entry produces no o_wr_en; after the rd 7 write, the rd 7 query → 0. With the macro undefined, the query always → 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Optional feature macro: REGFILE_WB_PENDING_CHK_EN (pending-destination query).
package regfile_wb_pkg;

   localparam int unsigned XLEN_DEF         = 32;
   localparam int unsigned AW_DEF           = 5;
   localparam int unsigned DEPTH_DEF        = 4;
   localparam int unsigned STARVE_LIMIT_DEF = 8;

   // Write-back payload at default widths; rd sits in the MSBs, matching the FIFO packing.
   typedef struct packed {
      logic [AW_DEF-1:0]   rd;
      logic [XLEN_DEF-1:0] data;
   } wb_req_t;

   // Packed payload width for arbitrary parameterisations.
   function automatic int unsigned wb_req_w(int unsigned aw, int unsigned xlen);
      return aw + xlen;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests {rd, data}.
// With REGFILE_WB_PENDING_CHK_EN defined, it also exposes per-slot valid flags and rd fields.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int unsigned W     = wb_req_w(AW_DEF, XLEN_DEF),
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [W-1:0]        din,
   input  logic                pop,
   output logic [W-1:0]        dout,
`ifdef REGFILE_WB_PENDING_CHK_EN
   output logic [DEPTH-1:0]    ent_valid,
   output logic [DEPTH*AW-1:0] ent_rd,
`endif
   output logic                full,
   output logic                empty
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = PW + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[PW-1:0]];

   // Pointer update; reset discards every queued entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage write; contents need no reset since validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

`ifdef REGFILE_WB_PENDING_CHK_EN
   logic [PTR_W-1:0] count;
   assign count = wr_ptr - rd_ptr;

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_valid[i]        = (PTR_W'(PW'(PW'(i) - rd_ptr[PW-1:0])) < count);
         ent_rd[i*AW +: AW]  = mem[i][W-1 -: AW];
      end
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter merging ALU and queued LSU results onto one register-file write port.
// Optional feature macro: REGFILE_WB_PENDING_CHK_EN enables the o_chk_pending comparators;
// without it o_chk_pending is tied low.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int unsigned XLEN         = XLEN_DEF,
   parameter int unsigned AW           = AW_DEF,
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_alu_valid,
   output logic            o_alu_ready,
   input  logic [AW-1:0]   i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic            i_lsu_valid,
   output logic            o_lsu_ready,
   input  logic [AW-1:0]   i_lsu_rd,
   input  logic [XLEN-1:0] i_lsu_data,
   output logic            o_wr_en,
   output logic [AW-1:0]   o_wr_addr,
   output logic [XLEN-1:0] o_wr_data,
   input  logic [AW-1:0]   i_chk_rd,
   output logic            o_chk_pending
);

   localparam int unsigned REQ_W = wb_req_w(AW, XLEN);
   localparam int unsigned CW    = $clog2(STARVE_LIMIT + 1);

   logic             full;
   logic             empty;
   logic [REQ_W-1:0] head;
   logic [AW-1:0]    head_rd;
   logic [XLEN-1:0]  head_data;
   logic             forced;
   logic             alu_xfer;
   logic             lsu_push;
   logic             pop;
   logic [CW-1:0]    starve_cnt;
   logic [CW-1:0]    starve_nxt;
   logic             wr_en_nxt;
   logic [AW-1:0]    wr_addr_nxt;
   logic [XLEN-1:0]  wr_data_nxt;

   assign head_rd   = head[REQ_W-1 -: AW];
   assign head_data = head[XLEN-1:0];

   // Forced drain steals one ALU slot once the queue head has waited long enough.
   assign forced      = (starve_cnt == CW'(STARVE_LIMIT)) && !empty;
   assign o_alu_ready = !forced;
   assign o_lsu_ready = !full;
   assign alu_xfer    = i_alu_valid && o_alu_ready;
   assign lsu_push    = i_lsu_valid && !full;
   assign pop         = !alu_xfer && !empty;

`ifdef REGFILE_WB_PENDING_CHK_EN
   logic [DEPTH-1:0]    ent_valid;
   logic [DEPTH*AW-1:0] ent_rd;
`endif

   wb_fifo #(
      .W     (REQ_W),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lsu_push),
      .din       ({i_lsu_rd, i_lsu_data}),
      .pop       (pop),
      .dout      (head),
`ifdef REGFILE_WB_PENDING_CHK_EN
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
`endif
      .full      (full),
      .empty     (empty)
   );

   // Select the write source and advance the starvation counter.
   always_comb begin
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = o_wr_addr;
      wr_data_nxt = o_wr_data;
      starve_nxt  = starve_cnt;
      if (alu_xfer) begin
         wr_en_nxt   = (i_alu_rd != '0);
         wr_addr_nxt = i_alu_rd;
         wr_data_nxt = i_alu_data;
      end else if (!empty) begin
         wr_en_nxt   = (head_rd != '0);
         wr_addr_nxt = head_rd;
         wr_data_nxt = head_data;
      end
      if (empty || pop) starve_nxt = '0;
      else              starve_nxt = CW'(starve_cnt + CW'(1));
   end

   // Registered write port and starvation counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_wr_en    <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         starve_cnt <= '0;
      end else begin
         o_wr_en    <= wr_en_nxt;
         o_wr_addr  <= wr_addr_nxt;
         o_wr_data  <= wr_data_nxt;
         starve_cnt <= starve_nxt;
      end
   end

`ifdef REGFILE_WB_PENDING_CHK_EN
   // Flag a queried destination that still has a load result waiting in the FIFO.
   always_comb begin
      o_chk_pending = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_rd[i*AW +: AW] == i_chk_rd) && (i_chk_rd != '0))
            o_chk_pending = 1'b1;
      end
   end
`else
   logic unused_chk;
   assign unused_chk    = ^i_chk_rd;
   assign o_chk_pending = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_regfile_wb_arbiter;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned AW           = 5;
   localparam int unsigned DEPTH        = 4;
   localparam int unsigned STARVE_LIMIT = 8;
`ifdef REGFILE_WB_PENDING_CHK_EN
   localparam bit PEND_EN = 1'b1;
`else
   localparam bit PEND_EN = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0;
   logic            alu_ready;
   logic [AW-1:0]   alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            lsu_valid = 1'b0;
   logic            lsu_ready;
   logic [AW-1:0]   lsu_rd = '0;
   logic [XLEN-1:0] lsu_data = '0;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [AW-1:0]   chk_rd = '0;
   logic            chk_pending;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_alu_valid   (alu_valid),
      .o_alu_ready   (alu_ready),
      .i_alu_rd      (alu_rd),
      .i_alu_data    (alu_data),
      .i_lsu_valid   (lsu_valid),
      .o_lsu_ready   (lsu_ready),
      .i_lsu_rd      (lsu_rd),
      .i_lsu_data    (lsu_data),
      .o_wr_en       (wr_en),
      .o_wr_addr     (wr_addr),
      .o_wr_data     (wr_data),
      .i_chk_rd      (chk_rd),
      .o_chk_pending (chk_pending)
   );

   // Model state: queued load results in acceptance order, and how long the head has waited.
   ent_t        q[$];
   int unsigned starve = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        seen_alu_ready, seen_lsu_ready, seen_pending;
   bit          m_alu_x = 1'b0;
   bit          m_lsu_x = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check handshake outputs, predict the write, then check it after the edge.
   task automatic step();
      bit   exp_alu_rdy, exp_lsu_rdy, exp_pend, was_empty, popped, exp_en, chk_ad;
      logic [AW-1:0]   exp_addr;
      logic [XLEN-1:0] exp_data;
      ent_t e;
      exp_en = 1'b0; chk_ad = 1'b0; exp_addr = '0; exp_data = '0; popped = 1'b0;
      #1;
      seen_alu_ready = alu_ready;
      seen_lsu_ready = lsu_ready;
      seen_pending   = chk_pending;
      if (!rst_n) begin
         q.delete();
         starve  = 0;
         m_alu_x = 1'b0;
         m_lsu_x = 1'b0;
         chk_ad  = 1'b1;
      end else begin
         exp_alu_rdy = !((q.size() != 0) && (starve == STARVE_LIMIT));
         exp_lsu_rdy = (q.size() < DEPTH);
         exp_pend = 1'b0;
         if (PEND_EN && chk_rd != '0)
            foreach (q[i]) if (q[i].rd == chk_rd) exp_pend = 1'b1;
         check("alu_ready", 32'(alu_ready), 32'(exp_alu_rdy));
         check("lsu_ready", 32'(lsu_ready), 32'(exp_lsu_rdy));
         check("chk_pending", 32'(chk_pending), 32'(exp_pend));
         m_alu_x   = alu_valid && exp_alu_rdy;
         m_lsu_x   = lsu_valid && exp_lsu_rdy;
         was_empty = (q.size() == 0);
         if (m_alu_x) begin
            exp_en = (alu_rd != '0); exp_addr = alu_rd; exp_data = alu_data; chk_ad = exp_en;
         end else if (!was_empty) begin
            e = q.pop_front();
            popped = 1'b1;
            exp_en = (e.rd != '0); exp_addr = e.rd; exp_data = e.data; chk_ad = exp_en;
         end
         if (popped || was_empty) starve = 0;
         else                     starve++;
         if (m_lsu_x) q.push_back('{rd: lsu_rd, data: lsu_data});
      end
      @(posedge clk);
      #1;
      check("wr_en", 32'(wr_en), 32'(exp_en));
      if (chk_ad) begin
         check("wr_addr", 32'(wr_addr), 32'(exp_addr));
         check("wr_data", wr_data, exp_data);
      end
   endtask

   initial begin : main
      int unsigned bp_addr[5];
      int          first_low, low_cnt, got9;
      int unsigned alu_pct, lsu_pct;
      bp_addr = '{4, 5, 6, 7, 8};

      // Reset with both sources asserting valid.
      rst_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h5;
      step(); step();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      check("rst_pending", 32'(chk_pending), 32'd0);

      // First ALU transfer after release.
      rst_n = 1'b1; lsu_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5;
      step();
      check("alu_first_en", 32'(wr_en), 32'd1);
      check("alu_first_addr", 32'(wr_addr), 32'd3);
      check("alu_first_data", wr_data, 32'hA5A5_A5A5);

      // ALU and LSU together: ALU first, LSU the next cycle.
      alu_rd = 5'd1; alu_data = 32'h11; lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
      step();
      check("arb_alu_addr", 32'(wr_addr), 32'd1);
      check("arb_alu_data", wr_data, 32'h11);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      step();
      check("arb_lsu_en", 32'(wr_en), 32'd1);
      check("arb_lsu_addr", 32'(wr_addr), 32'd2);
      check("arb_lsu_data", wr_data, 32'h22);

      // Backpressure: fill the FIFO under a busy ALU, then drain in push order.
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1234;
      for (int k = 0; k < 4; k++) begin
         lsu_valid = 1'b1; lsu_rd = AW'(4 + k); lsu_data = 32'h40 + 32'(k);
         step();
         check("bp_accept", 32'(seen_lsu_ready), 32'd1);
      end
      lsu_rd = 5'd8; lsu_data = 32'h88;
      step();
      check("bp_full", 32'(seen_lsu_ready), 32'd0);
      alu_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0) check("bp_ready_during_first_pop", 32'(seen_lsu_ready), 32'd0);
         if (k == 1) begin
            check("bp_ready_after_pop", 32'(seen_lsu_ready), 32'd1);
            lsu_valid = 1'b0;
         end
         check("bp_order", 32'(wr_addr), bp_addr[k]);
      end

      // Starvation: one queued entry behind a continuously valid ALU.
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0B0;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
      step();
      lsu_valid = 1'b0;
      first_low = -1; low_cnt = 0; got9 = -1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!seen_alu_ready) begin
            low_cnt++;
            if (first_low < 0) first_low = k;
         end
         if (wr_en && wr_addr == 5'd9) got9 = k;
      end
      check("starve_first_low", 32'(first_low), 32'd8);
      check("starve_low_cycles", 32'(low_cnt), 32'd1);
      check("starve_write_cycle", 32'(got9), 32'd8);

      // x0 discard and pending query.
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0D;
      step();
      lsu_rd = 5'd7; lsu_data = 32'h77;
      step();
      lsu_valid = 1'b0; chk_rd = 5'd7;
      step();
      check("pend_rd7", 32'(seen_pending), 32'(PEND_EN));
      chk_rd = 5'd0;
      step();
      check("pend_rd0", 32'(seen_pending), 32'd0);
      alu_valid = 1'b0; chk_rd = 5'd7;
      step();
      check("x0_no_write", 32'(wr_en), 32'd0);
      step();
      check("rd7_en", 32'(wr_en), 32'd1);
      check("rd7_addr", 32'(wr_addr), 32'd7);
      check("rd7_data", wr_data, 32'h77);
      step();
      check("pend_rd7_after", 32'(seen_pending), 32'd0);

      // Randomized traffic with occasional mid-run resets.
      alu_valid = 1'b0; lsu_valid = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         case ((c / 400) % 3)
            0:       begin alu_pct = 30; lsu_pct = 60; end
            1:       begin alu_pct = 95; lsu_pct = 50; end
            default: begin alu_pct = 70; lsu_pct = 90; end
         endcase
         if (c % 700 == 650) begin
            rst_n = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
            step(); step();
            rst_n = 1'b1;
         end
         if (!alu_valid || m_alu_x) begin
            alu_valid = ($urandom_range(99) < alu_pct);
            alu_rd    = AW'($urandom_range(7));
            alu_data  = $urandom;
         end
         if (!lsu_valid || m_lsu_x) begin
            lsu_valid = ($urandom_range(99) < lsu_pct);
            lsu_rd    = AW'($urandom_range(7));
            lsu_data  = $urandom;
         end
         chk_rd = AW'($urandom_range(7));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
